// File: rtl/ice_uart_pkg.sv
// Shared types and constants for the ice UART blocks.
// State encodings are fixed so the 8E1 build (ICE_UART_RX_PARITY_EN) keeps the same values as 8N1.
package ice_uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 104;  // 12 MHz / 115200

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4,
    PARITY  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/ice_sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
// The reset value is a parameter so idle-high and idle-low lines can share this block.
module ice_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/ice_uart_rx.sv
// UART receiver, 8N1 LSB first, with a valid/ready byte output and error pulses.
// Define ICE_UART_RX_PARITY_EN for 8E1 framing and the o_parity_err output.
//
// state   | meaning
// IDLE    | line idle, waiting for a low level
// START   | half-bit wait, then confirm the start bit
// DATA    | sample 8 data bits at bit centres
// PARITY  | sample the even-parity bit (8E1 build only)
// STOP    | sample the stop bit and deliver or discard the byte
// WAIT_HI | framing error seen, wait for the line to go high
module ice_uart_rx
  import ice_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  input  logic                   i_ready,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_frame_err,
  output logic                   o_overrun,
`ifdef ICE_UART_RX_PARITY_EN
  output logic                   o_parity_err,
`endif
  output logic                   o_busy
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  logic                   rx_s;
  uart_state_e            state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic [UART_DATA_W-1:0] shreg, shreg_nxt;
  logic                   cnt_tc;
  logic                   byte_done;
  logic                   frame_fail;
`ifdef ICE_UART_RX_PARITY_EN
  logic                   par_bit, par_bit_nxt;
  logic                   parity_fail;
`endif

  ice_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  // Bit timer is a down-counter loaded on state entry; action happens at zero.
  assign cnt_tc = (cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef ICE_UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
`ifdef ICE_UART_RX_PARITY_EN
      par_bit <= par_bit_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    byte_done   = 1'b0;
    frame_fail  = 1'b0;
`ifdef ICE_UART_RX_PARITY_EN
    par_bit_nxt = par_bit;
    parity_fail = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = HALF_TC;
        end
      end
      START: begin
        if (cnt_tc) begin
          if (!rx_s) begin
            state_nxt   = DATA;
            cnt_nxt     = BIT_TC;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_tc) begin
          shreg_nxt   = {rx_s, shreg[UART_DATA_W-1:1]};
          cnt_nxt     = BIT_TC;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef ICE_UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`ifdef ICE_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_tc) begin
          par_bit_nxt = rx_s;
          cnt_nxt     = BIT_TC;
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_tc) begin
          if (!rx_s) begin
            // Framing error takes priority over a parity error.
            frame_fail = 1'b1;
            state_nxt  = WAIT_HI;
          end else begin
`ifdef ICE_UART_RX_PARITY_EN
            if (^{shreg, par_bit}) parity_fail = 1'b1;
            else                   byte_done   = 1'b1;
`else
            byte_done = 1'b1;
`endif
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new byte always wins; an accept in the same cycle is not an overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef ICE_UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err  <= frame_fail;
      o_overrun    <= byte_done && o_valid && !i_ready;
`ifdef ICE_UART_RX_PARITY_EN
      o_parity_err <= parity_fail;
`endif
      if (byte_done) begin
        o_data  <= shreg;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_ice_uart_rx.sv
// Directed plus randomized bench for ice_uart_rx at 16 clocks per bit.
// Expected bytes and error counts come from a frame-level model of what was sent.
module tb_ice_uart_rx;

  localparam int CPB = 16;
`ifdef ICE_UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT_NOM = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
`ifdef ICE_UART_RX_PARITY_EN
  logic       o_parity_err;
  logic       par_good = 1'b1;
  int         par_n = 0;
`endif

  ice_uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx         (rx),
    .i_ready      (ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
`ifdef ICE_UART_RX_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Running event totals; tests compare differences against snapshots.
  logic [7:0]  acc_q[$];
  int          valid_hi = 0, ovr_n = 0, frm_n = 0, both_n = 0, busy_n = 0;
  int unsigned valid_rise = 0;
  logic [7:0]  ovr_data = 8'h00;
  logic        valid_d = 1'b0;

  always @(negedge clk) begin
    if (o_valid && ready) acc_q.push_back(o_data);
    if (o_valid && !valid_d) valid_rise = cyc;
    if (o_valid) valid_hi++;
    if (o_overrun) begin
      ovr_n++;
      ovr_data = o_data;
    end
    if (o_frame_err) frm_n++;
    if (o_frame_err && o_overrun) both_n++;
    if (o_busy) busy_n++;
`ifdef ICE_UART_RX_PARITY_EN
    if (o_parity_err) par_n++;
`endif
    valid_d = o_valid;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] acc_at(input int i);
    if (i >= 0 && i < acc_q.size()) return acc_q[i];
    return 8'hxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  int unsigned start_cyc;

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    start_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef ICE_UART_RX_PARITY_EN
    hold((^d) ^ !par_good, CPB);
`endif
    hold(stop_ok, CPB);
  endtask

  int         a0, v0, f0, o0, b0;
  int unsigned lat;
  logic [7:0] exp_q[$];
  int         exp_frm;
`ifdef ICE_UART_RX_PARITY_EN
  int         p0, exp_par;
`endif

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_data", o_data, 0);
    check("rst_valid", o_valid, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_busy", o_busy, 0);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);

    // single byte, ready high
    ready = 1'b1;
    a0 = acc_q.size(); v0 = valid_hi; f0 = frm_n; o0 = ovr_n;
    send_frame(8'hA5, 1'b1);
    hold(1'b1, CPB);
    lat = valid_rise - start_cyc;
    check("t1_count", acc_q.size() - a0, 1);
    check("t1_data", acc_at(a0), 8'hA5);
    check("t1_valid_cycles", valid_hi - v0, 1);
    check("t1_frame_err", frm_n - f0, 0);
    check("t1_overrun", ovr_n - o0, 0);
    check("t1_latency_in_window", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 2), 1);

    // overrun with ready low
    ready = 1'b0;
    a0 = acc_q.size(); o0 = ovr_n;
    send_frame(8'h3C, 1'b1);
    check("t2_no_ovr_first", ovr_n - o0, 0);
    send_frame(8'hC3, 1'b1);
    hold(1'b1, CPB);
    check("t2_ovr_count", ovr_n - o0, 1);
    check("t2_ovr_data", ovr_data, 8'hC3);
    check("t2_valid", o_valid, 1);
    check("t2_data", o_data, 8'hC3);
    check("t2_no_accept", acc_q.size() - a0, 0);
    ready = 1'b1;
    tick();
    tick();
    check("t2_accept_count", acc_q.size() - a0, 1);
    check("t2_accept_data", acc_at(a0), 8'hC3);
    check("t2_valid_cleared", o_valid, 0);

    // framing error followed by a long break
    a0 = acc_q.size(); v0 = valid_hi; f0 = frm_n;
    send_frame(8'h55, 1'b0);
    hold(1'b0, 40 * CPB);
    check("t3_busy_in_break", o_busy, 1);
    check("t3_frame_err_once", frm_n - f0, 1);
    check("t3_no_valid", valid_hi - v0, 0);
    hold(1'b1, 2 * CPB);
    check("t3_idle_after_break", o_busy, 0);
    send_frame(8'h12, 1'b1);
    hold(1'b1, CPB);
    check("t3_next_count", acc_q.size() - a0, 1);
    check("t3_next_data", acc_at(a0), 8'h12);
    check("t3_frame_err_total", frm_n - f0, 1);

    // short glitch rejected
    a0 = acc_q.size(); b0 = busy_n; v0 = valid_hi;
    hold(1'b0, 5);
    hold(1'b1, 2 * CPB);
    check("t4_busy_cycles", busy_n - b0, 8);
    check("t4_no_valid", valid_hi - v0, 0);
    check("t4_idle", o_busy, 0);

    // reset mid-frame with a pending byte
    ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    hold(1'b1, CPB);
    check("t5_pending_valid", o_valid, 1);
    a0 = acc_q.size();
    hold(1'b0, CPB);
    hold(1'b1, 4 * CPB + 8);
    check("t5_busy_before_rst", o_busy, 1);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", o_valid, 0);
    check("t5_rst_data", o_data, 0);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_frame_err", o_frame_err, 0);
    check("t5_rst_overrun", o_overrun, 0);
    rst = 1'b0;
    hold(1'b1, 5 * CPB);
    check("t5_idle_after", o_busy, 0);
    ready = 1'b1;
    send_frame(8'h81, 1'b1);
    hold(1'b1, CPB);
    check("t5_next_count", acc_q.size() - a0, 1);
    check("t5_next_data", acc_at(a0), 8'h81);

`ifdef ICE_UART_RX_PARITY_EN
    // parity error then good parity
    a0 = acc_q.size(); p0 = par_n; f0 = frm_n;
    par_good = 1'b0;
    send_frame(8'h07, 1'b1);
    hold(1'b1, CPB);
    check("t6_parity_err", par_n - p0, 1);
    check("t6_no_byte", acc_q.size() - a0, 0);
    check("t6_no_frame_err", frm_n - f0, 0);
    par_good = 1'b1;
    send_frame(8'h07, 1'b1);
    hold(1'b1, CPB);
    check("t6_good_count", acc_q.size() - a0, 1);
    check("t6_good_data", acc_at(a0), 8'h07);
    check("t6_parity_total", par_n - p0, 1);
    p0 = par_n;
    exp_par = 0;
`endif

    // randomized frames against the frame-level model
    a0 = acc_q.size(); f0 = frm_n;
    exp_q.delete();
    exp_frm = 0;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       stop_ok;
      d = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
`ifdef ICE_UART_RX_PARITY_EN
      par_good = ($urandom_range(0, 3) != 0);
      if (!stop_ok) exp_frm++;
      else if (!par_good) exp_par++;
      else exp_q.push_back(d);
`else
      if (!stop_ok) exp_frm++;
      else exp_q.push_back(d);
`endif
      send_frame(d, stop_ok);
      if (!stop_ok) hold(1'b0, $urandom_range(0, 3 * CPB));
      hold(1'b1, CPB + $urandom_range(0, 2 * CPB));
    end
    check("rnd_count", acc_q.size() - a0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rnd_data%0d", i), acc_at(a0 + i), exp_q[i]);
    check("rnd_frame_err", frm_n - f0, exp_frm);
`ifdef ICE_UART_RX_PARITY_EN
    check("rnd_parity_err", par_n - p0, exp_par);
`endif
    check("never_frame_and_overrun", both_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
